// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types and constants for the branch predictor: BHT counter encodings
// and the in-flight queue entry layout.
package branch_predict_ctrl_pkg;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   localparam logic [1:0] BHT_RESET = WNT;

   // Queue entries carry a full PC; the top is instantiated with PC_W equal to this.
   localparam int BQ_PC_W = 32;

   typedef struct packed {
      logic [BQ_PC_W-1:0] pc;
      logic               pred;
   } bq_entry_t;

endpackage

// File: rtl/branch_predict_ctrl_bp_inflight_fifo.sv
// In-order FIFO of predicted branches awaiting resolution. Clear wins over
// push/pop; a push into a full FIFO is accepted only alongside a pop.
module bp_inflight_fifo
   import branch_predict_ctrl_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  bq_entry_t     i_din,
   input  logic          i_pop,
   input  logic          i_clear,
   output bq_entry_t     o_dout,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);

   bq_entry_t     r_mem [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic w_do_pop;
   logic w_do_push;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_head];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_tail <= r_tail + PW'(1);
         if (w_do_pop)  r_head <= r_head + PW'(1);
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   // Storage needs no reset: entries are only read while counted as valid.
   always_ff @(posedge clk) begin
      if (w_do_push && !i_clear) r_mem[r_tail] <= i_din;
   end

endmodule

// File: rtl/saturating_counter_2bit.sv
// Combinational 2-bit saturating counter step: up on taken, down on not-taken,
// holding at ST / SNT.
module saturating_counter_2bit
   import branch_predict_ctrl_pkg::*;
(
   input  logic [1:0] i_cnt,
   input  logic       i_taken,
   output logic [1:0] o_cnt
);

   always_comb begin
      o_cnt = i_cnt;
      if (i_taken) begin
         if (i_cnt != ST) o_cnt = i_cnt + 2'd1;
      end else begin
         if (i_cnt != SNT) o_cnt = i_cnt - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predictor control: BHT lookup in IF, in-flight queue of predictions,
// resolution in EXE with counter update, mispredict flush/redirect and perf counters.
module branch_predict_ctrl
   import branch_predict_ctrl_pkg::*;
#(
   parameter  int IDX_BITS = 4,
   parameter  int QDEPTH   = 4,
   parameter  int PC_W     = BQ_PC_W,
   parameter  int PERF_W   = 16,
   localparam int CW       = $clog2(QDEPTH) + 1,
   localparam int BHT_N    = 2 ** IDX_BITS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic              if_is_branch,
   input  logic [PC_W-1:0]   if_pc,
   output logic              pred_taken,
   output logic              if_stall,
   input  logic              ex_valid,
   input  logic              ex_taken,
   input  logic [PC_W-1:0]   ex_target,
   output logic              flush,
   output logic [PC_W-1:0]   redirect_pc,
   output logic [CW-1:0]     q_count,
   output logic [PERF_W-1:0] perf_branches,
   output logic [PERF_W-1:0] perf_mispred
);

   logic [1:0]        r_bht [BHT_N];
   logic              r_flush;
   logic [PC_W-1:0]   r_redirect_pc;
   logic [PERF_W-1:0] r_perf_br;
   logic [PERF_W-1:0] r_perf_mp;

   logic [IDX_BITS-1:0] w_lookup_idx;
   logic [IDX_BITS-1:0] w_upd_idx;
   logic [1:0]          w_bht_next;
   logic [PC_W-1:0]     w_head_pc;
   logic [PC_W-1:0]     w_redirect_next;
   logic                w_full;
   logic                w_empty;
   logic                w_pop;
   logic                w_push;
   logic                w_mispredict;
   bq_entry_t           w_push_entry;
   bq_entry_t           w_head;

   // IF side: a branch is accepted on any cycle if_stall=0. EXE side has no
   // backpressure: ex_valid pops the head whenever the queue is non-empty.
   assign w_lookup_idx = if_pc[IDX_BITS+1:2];
   assign pred_taken   = r_bht[w_lookup_idx][1];

   assign w_pop        = ex_valid & ~w_empty;
   assign w_head_pc    = PC_W'(w_head.pc);
   assign w_mispredict = w_pop & (w_head.pred != ex_taken);
   assign if_stall     = if_valid & if_is_branch & w_full & ~w_pop;
   assign w_push       = if_valid & if_is_branch & ~if_stall & ~w_mispredict;

   assign w_push_entry.pc   = BQ_PC_W'(if_pc);
   assign w_push_entry.pred = pred_taken;

   bp_inflight_fifo #(
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .i_push  (w_push),
      .i_din   (w_push_entry),
      .i_pop   (w_pop),
      .i_clear (w_mispredict),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (q_count)
   );

   assign w_upd_idx = w_head_pc[IDX_BITS+1:2];

   saturating_counter_2bit u_sat (
      .i_cnt   (r_bht[w_upd_idx]),
      .i_taken (ex_taken),
      .o_cnt   (w_bht_next)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BHT_N; i++) r_bht[i] <= BHT_RESET;
      end else if (w_pop) begin
         r_bht[w_upd_idx] <= w_bht_next;
      end
   end

   assign w_redirect_next = ex_taken ? ex_target : (w_head_pc + PC_W'(4));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_flush       <= 1'b0;
         r_redirect_pc <= '0;
         r_perf_br     <= '0;
         r_perf_mp     <= '0;
      end else begin
         r_flush <= w_mispredict;
         if (w_mispredict) r_redirect_pc <= w_redirect_next;
         if (w_pop && (r_perf_br != '1)) r_perf_br <= r_perf_br + PERF_W'(1);
         if (w_mispredict && (r_perf_mp != '1)) r_perf_mp <= r_perf_mp + PERF_W'(1);
      end
   end

   assign flush         = r_flush;
   assign redirect_pc   = r_redirect_pc;
   assign perf_branches = r_perf_br;
   assign perf_mispred  = r_perf_mp;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: a default instance plus a PERF_W=4
// instance sharing the same stimulus to exercise perf counter saturation.
module tb_branch_predict_ctrl;

   logic        clk;
   logic        rst;
   logic        if_valid;
   logic        if_is_branch;
   logic [31:0] if_pc;
   logic        ex_valid;
   logic        ex_taken;
   logic [31:0] ex_target;

   logic        pred_taken;
   logic        if_stall;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [2:0]  q_count;
   logic [15:0] perf_branches;
   logic [15:0] perf_mispred;

   logic        s_pred_taken;
   logic        s_if_stall;
   logic        s_flush;
   logic [31:0] s_redirect_pc;
   logic [2:0]  s_q_count;
   logic [3:0]  s_perf_branches;
   logic [3:0]  s_perf_mispred;

   int total;
   int bad;

   branch_predict_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .if_valid      (if_valid),
      .if_is_branch  (if_is_branch),
      .if_pc         (if_pc),
      .pred_taken    (pred_taken),
      .if_stall      (if_stall),
      .ex_valid      (ex_valid),
      .ex_taken      (ex_taken),
      .ex_target     (ex_target),
      .flush         (flush),
      .redirect_pc   (redirect_pc),
      .q_count       (q_count),
      .perf_branches (perf_branches),
      .perf_mispred  (perf_mispred)
   );

   branch_predict_ctrl #(.PERF_W(4)) dut_small (
      .clk           (clk),
      .rst           (rst),
      .if_valid      (if_valid),
      .if_is_branch  (if_is_branch),
      .if_pc         (if_pc),
      .pred_taken    (s_pred_taken),
      .if_stall      (s_if_stall),
      .ex_valid      (ex_valid),
      .ex_taken      (ex_taken),
      .ex_target     (ex_target),
      .flush         (s_flush),
      .redirect_pc   (s_redirect_pc),
      .q_count       (s_q_count),
      .perf_branches (s_perf_branches),
      .perf_mispred  (s_perf_mispred)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_valid     = 1'b0;
      if_is_branch = 1'b0;
      ex_valid     = 1'b0;
      ex_taken     = 1'b0;
      ex_target    = 32'h0;
   endtask

   task automatic set_push(input logic [31:0] pc);
      if_valid     = 1'b1;
      if_is_branch = 1'b1;
      if_pc        = pc;
   endtask

   task automatic lookup(input logic [31:0] pc);
      if_valid     = 1'b0;
      if_is_branch = 1'b0;
      if_pc        = pc;
      #1;
   endtask

   // Push one branch, then resolve it on the following cycle with the IF side idle.
   task automatic push_resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
      set_push(pc);
      ex_valid = 1'b0;
      tick();
      if_valid     = 1'b0;
      if_is_branch = 1'b0;
      ex_valid     = 1'b1;
      ex_taken     = taken;
      ex_target    = tgt;
      tick();
      ex_valid = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      if_pc = 32'h100;
      idle();
      #12;
      chk("rst_q_count", q_count, 0);
      chk("rst_flush", flush, 0);
      chk("rst_redirect", redirect_pc, 0);
      chk("rst_perf_br", perf_branches, 0);
      chk("rst_perf_mp", perf_mispred, 0);
      lookup(32'h100);
      chk("rst_pred_0x100", pred_taken, 0);
      rst = 1'b1;

      // First branch mispredicts taken
      tick();
      set_push(32'h100);
      #1;
      chk("push1_stall", if_stall, 0);
      tick();
      chk("push1_q", q_count, 1);
      idle();
      ex_valid  = 1'b1;
      ex_taken  = 1'b1;
      ex_target = 32'h200;
      tick();
      chk("mp1_flush", flush, 1);
      chk("mp1_redirect", redirect_pc, 32'h200);
      chk("mp1_perf_mp", perf_mispred, 1);
      chk("mp1_perf_br", perf_branches, 1);
      chk("mp1_q", q_count, 0);
      idle();
      lookup(32'h100);
      chk("mp1_pred_after", pred_taken, 1);
      tick();
      chk("mp1_flush_one_cycle", flush, 0);

      // Fill the queue, then stall, then pop+push when full
      for (int i = 0; i < 4; i++) begin
         set_push(32'h10 + 32'(4 * i));
         tick();
      end
      chk("fill_q", q_count, 4);
      set_push(32'h20);
      #1;
      chk("full_stall", if_stall, 1);
      tick();
      chk("full_stall_q", q_count, 4);
      ex_valid = 1'b1;
      ex_taken = 1'b0;
      #1;
      chk("full_poppush_stall", if_stall, 0);
      tick();
      chk("full_poppush_q", q_count, 4);
      chk("full_poppush_flush", flush, 0);
      chk("full_poppush_br", perf_branches, 2);

      // Drain with correct not-taken resolutions
      idle();
      ex_valid = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("drain_q", q_count, 0);
      chk("drain_br", perf_branches, 6);
      chk("drain_mp", perf_mispred, 1);
      idle();

      // Head at 0x40 predicted taken resolves not-taken with a push in flight
      set_push(32'h40);
      #1;
      chk("pred_0x40", pred_taken, 1);
      tick();
      set_push(32'h44);
      tick();
      set_push(32'h48);
      tick();
      chk("three_q", q_count, 3);
      set_push(32'h4C);
      ex_valid  = 1'b1;
      ex_taken  = 1'b0;
      ex_target = 32'h999;
      #1;
      chk("squash_stall", if_stall, 0);
      tick();
      chk("squash_flush", flush, 1);
      chk("squash_redirect", redirect_pc, 32'h44);
      chk("squash_q", q_count, 0);
      chk("squash_mp", perf_mispred, 2);
      chk("squash_br", perf_branches, 7);
      idle();
      tick();
      chk("squash_flush_end", flush, 0);
      chk("squash_q_after", q_count, 0);
      lookup(32'h40);
      chk("pred_0x40_after", pred_taken, 0);

      // ex_valid on empty queue with a simultaneous push
      set_push(32'h0C);
      ex_valid  = 1'b1;
      ex_taken  = 1'b1;
      ex_target = 32'h300;
      tick();
      chk("empty_pop_flush", flush, 0);
      chk("empty_pop_br", perf_branches, 7);
      chk("empty_pop_q", q_count, 1);
      idle();
      lookup(32'h40);
      chk("empty_pop_bht", pred_taken, 0);

      // Resolve 0x0C taken (predicted not-taken), then drive idx 3 to saturation
      ex_valid  = 1'b1;
      ex_taken  = 1'b1;
      ex_target = 32'h500;
      tick();
      chk("idx3_flush", flush, 1);
      chk("idx3_redirect", redirect_pc, 32'h500);
      chk("idx3_mp", perf_mispred, 3);
      idle();
      for (int i = 0; i < 4; i++) push_resolve(32'h0C, 1'b1, 32'h500);
      chk("sat_flush", flush, 0);
      chk("sat_mp", perf_mispred, 3);
      chk("sat_br", perf_branches, 12);
      lookup(32'h0C);
      chk("sat_pred", pred_taken, 1);
      push_resolve(32'h0C, 1'b0, 32'h0);
      chk("sat_dn1_flush", flush, 1);
      chk("sat_dn1_redirect", redirect_pc, 32'h10);
      lookup(32'h0C);
      chk("sat_dn1_pred", pred_taken, 1);
      push_resolve(32'h0C, 1'b0, 32'h0);
      lookup(32'h0C);
      chk("sat_dn2_pred", pred_taken, 0);
      chk("sat_dn2_mp", perf_mispred, 5);
      chk("small_br_14", s_perf_branches, 14);

      // Perf counter saturation on the 4-bit instance
      for (int i = 0; i < 6; i++) push_resolve(32'h60, 1'b0, 32'h0);
      chk("perf_br_20", perf_branches, 20);
      chk("small_br_sat", s_perf_branches, 15);
      chk("small_mp_5", s_perf_mispred, 5);
      chk("perf_flush_0", flush, 0);

      // Asynchronous reset mid-flush
      push_resolve(32'h0C, 1'b1, 32'h500);
      chk("pre_rst_flush", flush, 1);
      chk("pre_rst_br", perf_branches, 21);
      chk("pre_rst_mp", perf_mispred, 6);
      lookup(32'h0C);
      chk("pre_rst_pred", pred_taken, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_flush", flush, 0);
      chk("arst_redirect", redirect_pc, 0);
      chk("arst_br", perf_branches, 0);
      chk("arst_mp", perf_mispred, 0);
      chk("arst_small_br", s_perf_branches, 0);
      chk("arst_q", q_count, 0);
      chk("arst_pred", pred_taken, 0);
      #1;
      rst = 1'b1;
      tick();
      chk("post_rst_q", q_count, 0);
      chk("post_rst_flush", flush, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Owns a table of 2-bit saturating counters, the branch history table (BHT).
- Looks up a prediction for each branch fetched in IF.
- Tracks in-flight predicted branches in an in-order queue until they resolve in EXE.
- On resolution it updates the counters, detects mispredicts, and issues a one-cycle flush plus redirect PC to the fetch/hazard logic.

Parameters:
- IDX_BITS, 4: BHT index width; the BHT has 2**IDX_BITS entries, indexed by pc[IDX_BITS+1:2].
- QDEPTH, 4: maximum number of in-flight unresolved branches; must be a power of 2, at least 2.
- PC_W, 32: PC width.
- PERF_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- if_valid  in  1  the IF stage holds a valid instruction.
- if_is_branch  in  1  the IF instruction is a conditional branch.
- if_pc  in  PC_W  PC of the IF instruction.
- pred_taken  out  1  combinational prediction: bit[1] of BHT[if_pc index].
- if_stall  out  1  asserted when if_valid & if_is_branch & queue full & no pop this cycle.
- ex_valid  in  1  a branch is resolving in EXE this cycle.
- ex_taken  in  1  actual branch outcome.
- ex_target  in  PC_W  actual taken target.
- flush  out  1  registered one-cycle pulse on mispredict.
- redirect_pc  out  PC_W  registered; valid while flush=1.
- q_count  out  log2(QDEPTH)+1  current queue occupancy.
- perf_branches  out  PERF_W  count of resolved branches, saturating.
- perf_mispred  out  PERF_W  count of mispredicts, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - all BHT entries = 2'b01 (weakly not-taken);
  - queue empty, q_count=0;
  - flush=0, redirect_pc=0;
  - both perf counters = 0.
- Lookup:
  - pred_taken is purely combinational from the current BHT contents.
  - An update to the same index in the same cycle is not bypassed: the lookup sees the pre-update value.
- Push:
  - Condition: if_valid & if_is_branch & ~if_stall & ~mispredict_now.
  - Action: write {if_pc, pred_taken} at the tail; the tail pointer wraps modulo QDEPTH.
- Pop / resolve:
  - Condition: ex_valid & queue non-empty. The head entry is the resolving branch (in-order resolution).
  - mispredict_now = head.pred != ex_taken.
  - BHT[head.pc index] gets the saturating update:
    - taken: 00->01->10->11, holds at 11;
    - not taken: 11->10->01->00, holds at 00.
  - perf_branches increments by 1, saturating at all-ones.
- Mispredict:
  - Next cycle: flush=1 for exactly one cycle.
  - redirect_pc = ex_taken ? ex_target : head.pc + 4 (modulo 2**PC_W).
  - perf_mispred increments, saturating.
  - In the same cycle, the whole queue is cleared (younger entries squashed) and any simultaneous push is discarded, giving q_count=0 next cycle.
- Correct prediction: head popped only; flush stays 0.
- Simultaneous push and pop, no mispredict: both happen and q_count is unchanged. This is legal even when the queue is full, so if_stall is deasserted in that case.
- ex_valid with an empty queue: ignored. No BHT update, no flush, no perf change.
- Pop while q_count=0 and push in the same cycle: the push is not forwarded to the pop. The pop is ignored as above and the push proceeds.
- Reset asserted mid-operation: state is lost immediately, and a flush pulse in progress is cut.
- Latency:
  - prediction: 0 cycles (combinational);
  - flush/redirect: 1 cycle after the resolving cycle;
  - BHT update visible to lookups: from the next cycle.

Decomposition:
- Shared package contents:
  - BHT counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - reset counter value WNT;
  - queue-entry struct {pc, pred}.
- One natural sub-module: bp_inflight_fifo, a QDEPTH-entry in-order FIFO with push, pop, clear, full, empty and count.
- The counter update reuses the team's existing saturating_counter_2bit combinational block, one instance on the update path.

Test Plan:
- Reset, then lookup at if_pc=0x100 -> pred_taken=0; q_count=0; flush=0.
- Push branch at 0x100 (pred 0), resolve next cycle with ex_taken=1, ex_target=0x200 -> flush=1 for one cycle, redirect_pc=0x200, perf_mispred=1, BHT[0]=10; a following lookup at 0x100 gives pred_taken=1.
- Fill the queue with 4 branches while EXE is idle -> q_count=4 and if_stall=1 on the 5th. Then the same cycle pop correct plus push -> if_stall=0 and q_count stays 4.
- Queue holds 3 entries and the head mispredicts (not taken, pc=0x40) while a push occurs -> q_count=0 next cycle, redirect_pc=0x44, push discarded.
- ex_valid=1 with empty queue -> no flush, perf_branches unchanged, BHT unchanged.
- Saturation:
  - 5 consecutive taken resolutions at index 3 -> counter holds at 11;
  - with PERF_W=4, 20 resolutions -> perf_branches=15.
  - Assert rst=0 asynchronously mid-burst -> all outputs return to reset values before the next clock edge.
